// File: rtl/prei_md_buf_pp_pkg.sv
// rtl/prei_md_buf_pp_pkg.sv - shared constants for the ping-pong mode-decision buffer
package prei_md_buf_pp_pkg;

  localparam int PREI_MD_DEPTH  = 85;
  localparam int PREI_MD_DAT_WD = 6;
  localparam int PREI_MD_RAM_WD = 8;
  localparam int PREI_MD_ADR_WD = $clog2(PREI_MD_DEPTH);

  function automatic logic adr_in_range(input logic [31:0] adr, input int depth);
    return adr < 32'(depth);
  endfunction

endpackage

// File: rtl/prei_md_buf_pp_if.sv
// rtl/prei_md_buf_pp_if.sv - producer/consumer handshake bundle for the mode-decision buffer
interface prei_md_buf_pp_if
  import prei_md_buf_pp_pkg::*;
#(
  parameter int ADR_WD = PREI_MD_ADR_WD,
  parameter int DAT_WD = PREI_MD_DAT_WD
);

  logic              wr_rdy_o;
  logic              wr_val_i;
  logic [ADR_WD-1:0] wr_adr_i;
  logic [DAT_WD-1:0] wr_dat_i;
  logic              wr_done_i;
  logic              rd_rdy_o;
  logic              rd_val_i;
  logic [ADR_WD-1:0] rd_adr_i;
  logic [DAT_WD-1:0] rd_dat_o;
  logic              rd_dat_vld_o;
  logic              rd_done_i;
  logic              err_o;

  modport master (
    input  wr_rdy_o, rd_rdy_o, rd_dat_o, rd_dat_vld_o, err_o,
    output wr_val_i, wr_adr_i, wr_dat_i, wr_done_i, rd_val_i, rd_adr_i, rd_done_i
  );

  modport slave (
    output wr_rdy_o, rd_rdy_o, rd_dat_o, rd_dat_vld_o, err_o,
    input  wr_val_i, wr_adr_i, wr_dat_i, wr_done_i, rd_val_i, rd_adr_i, rd_done_i
  );

endinterface

// File: rtl/prei_md_buf_pp_ram.sv
// rtl/prei_md_buf_pp_ram.sv - behavioural single-port RAM, low-active cen/wen/oen
module ram_1p #(
  parameter int Word_Width = 8,
  parameter int Addr_Width = 7
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  wen,
  input  logic                  oen,
  input  logic [Addr_Width-1:0] adr,
  input  logic [Word_Width-1:0] din,
  output logic [Word_Width-1:0] dout
);

  logic [Word_Width-1:0] mem [2**Addr_Width];
  logic [Word_Width-1:0] q;

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[adr] <= din;
      else      q        <= mem[adr];
    end
  end

  assign dout = oen ? '0 : q;

endmodule

// File: rtl/prei_md_buf_pp.sv
// rtl/prei_md_buf_pp.sv - two-bank ping-pong buffer of CTU partition modes
// Producer fills one bank while the consumer drains the other; full flags track ownership.
module prei_md_buf_pp
  import prei_md_buf_pp_pkg::*;
#(
  parameter int DEPTH  = PREI_MD_DEPTH,
  parameter int DAT_WD = PREI_MD_DAT_WD,
  parameter int RAM_WD = PREI_MD_RAM_WD,
  localparam int ADR_WD = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  prei_md_buf_pp_if.slave   bus
);

  logic [1:0]        full_q;
  logic              wr_bank;
  logic              rd_bank;
  logic              vld_q;
  logic              rd_sel_q;
  logic              err_q;
  logic [DAT_WD-1:0] hold_q;

  logic              wr_rdy;
  logic              rd_rdy;
  logic              wr_go;
  logic              rd_go;
  logic              err_ev;
  logic [DAT_WD-1:0] rd_dat;
  logic [RAM_WD-1:0] ram_q [2];

  assign wr_rdy = !full_q[wr_bank];
  assign rd_rdy =  full_q[rd_bank];

  assign wr_go = bus.wr_val_i && wr_rdy && adr_in_range(32'(bus.wr_adr_i), DEPTH);
  assign rd_go = bus.rd_val_i && rd_rdy && adr_in_range(32'(bus.rd_adr_i), DEPTH);

  assign err_ev = ((bus.wr_val_i || bus.wr_done_i) && !wr_rdy)
               || ((bus.rd_val_i || bus.rd_done_i) && !rd_rdy)
               || (bus.wr_val_i && !adr_in_range(32'(bus.wr_adr_i), DEPTH))
               || (bus.rd_val_i && !adr_in_range(32'(bus.rd_adr_i), DEPTH));

  // Done pulses target disjoint banks (one needs full, the other not-full), so both may fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      vld_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      if (bus.wr_done_i && wr_rdy) begin
        full_q[wr_bank] <= 1'b1;
        wr_bank         <= ~wr_bank;
      end
      if (bus.rd_done_i && rd_rdy) begin
        full_q[rd_bank] <= 1'b0;
        rd_bank         <= ~rd_bank;
      end
      vld_q <= rd_go;
      if (rd_go)  rd_sel_q <= rd_bank;
      if (vld_q)  hold_q   <= rd_dat;
      if (err_ev) err_q    <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic wr_hit;
    logic rd_hit;
    assign wr_hit = wr_go && (wr_bank == 1'(b));
    assign rd_hit = rd_go && (rd_bank == 1'(b));

    ram_1p #(
      .Word_Width (RAM_WD),
      .Addr_Width (ADR_WD)
    ) u_ram (
      .clk  (clk),
      .cen  (!(wr_hit || rd_hit)),
      .wen  (!wr_hit),
      .oen  (1'b0),
      .adr  (wr_hit ? bus.wr_adr_i : bus.rd_adr_i),
      .din  (RAM_WD'(bus.wr_dat_i)),
      .dout (ram_q[b])
    );
  end

  // RAM output only moves on a read, but the held copy gives a defined value after reset.
  assign rd_dat = vld_q ? ram_q[rd_sel_q][DAT_WD-1:0] : hold_q;

  assign bus.wr_rdy_o     = wr_rdy;
  assign bus.rd_rdy_o     = rd_rdy;
  assign bus.rd_dat_o     = rd_dat;
  assign bus.rd_dat_vld_o = vld_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_prei_md_buf_pp.sv
// tb/tb_prei_md_buf_pp.sv - directed scoreboard bench for the ping-pong mode-decision buffer
module tb_prei_md_buf_pp;
  import prei_md_buf_pp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prei_md_buf_pp_if bus ();

  prei_md_buf_pp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] patv(input int p, input int a);
    case (p)
      0:       return 6'(a);
      1:       return 6'(a * 3 + 1);
      2:       return 6'(a ^ 21);
      3:       return 6'(63 - a);
      default: return 6'(a * 5 + 7);
    endcase
  endfunction

  // Every cycle: the valid flag must match the scoreboard, and any expected word is compared.
  task automatic tick();
    logic [5:0] e;
    @(posedge clk);
    #1;
    chk("rd_vld", 32'(bus.rd_dat_vld_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rd_dat", 32'(bus.rd_dat_o), 32'(e));
    end
  endtask

  task automatic idle();
    bus.wr_val_i  = 1'b0;
    bus.wr_adr_i  = '0;
    bus.wr_dat_i  = '0;
    bus.wr_done_i = 1'b0;
    bus.rd_val_i  = 1'b0;
    bus.rd_adr_i  = '0;
    bus.rd_done_i = 1'b0;
  endtask

  task automatic fill(input int p);
    for (int i = 0; i < 85; i++) begin
      bus.wr_val_i = 1'b1;
      bus.wr_adr_i = 7'(i);
      bus.wr_dat_i = patv(p, i);
      tick();
    end
    bus.wr_val_i  = 1'b0;
    bus.wr_done_i = 1'b1;
    tick();
    bus.wr_done_i = 1'b0;
  endtask

  task automatic drain(input int p);
    for (int i = 0; i < 85; i++) begin
      bus.rd_val_i = 1'b1;
      bus.rd_adr_i = 7'(i);
      exp_q.push_back(patv(p, i));
      tick();
    end
    bus.rd_val_i  = 1'b0;
    bus.rd_done_i = 1'b1;
    tick();
    bus.rd_done_i = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wr_rdy", 32'(bus.wr_rdy_o), 32'd1);
    chk("rst_rd_rdy", 32'(bus.rd_rdy_o), 32'd0);
    chk("rst_err",    32'(bus.err_o),    32'd0);
    chk("rst_rd_dat", 32'(bus.rd_dat_o), 32'd0);

    // fill bank0, hand over, read back, release
    fill(0);
    chk("s1_rd_rdy", 32'(bus.rd_rdy_o), 32'd1);
    chk("s1_wr_rdy", 32'(bus.wr_rdy_o), 32'd1);
    drain(0);
    chk("s2_rd_rdy", 32'(bus.rd_rdy_o), 32'd0);
    chk("s2_hold",   32'(bus.rd_dat_o), 32'(patv(0, 84)));

    // both banks full: producer stalls, extra write ignored
    fill(1);
    fill(2);
    chk("s3_wr_rdy", 32'(bus.wr_rdy_o), 32'd0);
    chk("s3_rd_rdy", 32'(bus.rd_rdy_o), 32'd1);
    chk("s3_err0",   32'(bus.err_o),    32'd0);
    bus.wr_val_i = 1'b1;
    bus.wr_adr_i = 7'd3;
    bus.wr_dat_i = 6'h2A;
    tick();
    idle();
    chk("s3_err1", 32'(bus.err_o), 32'd1);
    drain(1);

    // concurrent drain of bank0 and fill of bank1, both dones on the last cycle
    for (int i = 0; i < 85; i++) begin
      bus.wr_val_i = 1'b1;
      bus.wr_adr_i = 7'(i);
      bus.wr_dat_i = patv(3, i);
      bus.rd_val_i = 1'b1;
      bus.rd_adr_i = 7'(i);
      exp_q.push_back(patv(2, i));
      if (i == 84) begin
        bus.wr_done_i = 1'b1;
        bus.rd_done_i = 1'b1;
      end
      tick();
    end
    idle();
    chk("s4_wr_rdy", 32'(bus.wr_rdy_o), 32'd1);
    chk("s4_rd_rdy", 32'(bus.rd_rdy_o), 32'd1);
    drain(3);
    chk("s4_rd_empty", 32'(bus.rd_rdy_o), 32'd0);
    chk("s4_err_sticky", 32'(bus.err_o), 32'd1);

    // out-of-range write, then read while nothing is readable
    pulse_rst();
    chk("s5_err_clr", 32'(bus.err_o), 32'd0);
    bus.wr_val_i = 1'b1;
    bus.wr_adr_i = 7'd85;
    bus.wr_dat_i = 6'h3F;
    tick();
    idle();
    chk("s5_wr_oor_err", 32'(bus.err_o), 32'd1);
    chk("s5_wr_oor_rdy", 32'(bus.rd_rdy_o), 32'd0);
    pulse_rst();
    bus.rd_val_i = 1'b1;
    tick();
    idle();
    chk("s5_rd_nrdy_err", 32'(bus.err_o), 32'd1);

    // async reset in the middle of a fill
    pulse_rst();
    bus.rd_done_i = 1'b1;
    tick();
    idle();
    chk("s6_err_pre", 32'(bus.err_o), 32'd1);
    for (int i = 0; i < 40; i++) begin
      bus.wr_val_i = 1'b1;
      bus.wr_adr_i = 7'(i);
      bus.wr_dat_i = patv(1, i);
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    chk("s6_async_wr_rdy", 32'(bus.wr_rdy_o), 32'd1);
    chk("s6_async_rd_rdy", 32'(bus.rd_rdy_o), 32'd0);
    chk("s6_async_err",    32'(bus.err_o),    32'd0);
    tick();
    rst = 1'b0;
    fill(4);
    bus.rd_val_i = 1'b1;
    bus.rd_adr_i = 7'd100;
    tick();
    idle();
    chk("s6_rd_oor_err",  32'(bus.err_o),    32'd1);
    chk("s6_rd_oor_hold", 32'(bus.rd_dat_o), 32'd0);
    drain(4);
    tick();
    chk("s6_final_hold", 32'(bus.rd_dat_o), 32'(patv(4, 84)));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
